// File: rtl/vc_skid_buffer_pkg.sv
// Shared state encoding and mux-select constants for the two-entry skid buffer.
package vc_skid_buffer_pkg;

  // Occupancy state; the encoding doubles as the count output.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  localparam logic MAIN_SEL_ENQ  = 1'b0;
  localparam logic MAIN_SEL_SKID = 1'b1;

endpackage

// File: rtl/vc_skid_buffer_ctrl.sv
// Skid buffer control: occupancy FSM, handshakes and datapath enables.
// Latency: outputs combinational from state (plus enq_val in EMPTY with VC_SKID_BUFFER_BYPASS_EN).
// Backpressure: enq_rdy drops only when both entries are held; never depends on deq_rdy.
module vc_skid_buffer_ctrl
  import vc_skid_buffer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enq_val,
  input  logic       deq_rdy,
  output logic       enq_rdy,
  output logic       deq_val,
  output logic [1:0] count,
  output logic       main_en,
  output logic       skid_en,
  output logic       main_sel
);

  state_t state_q;
  state_t state_d;
  logic   enq_fire;
  logic   deq_fire;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  // Handshakes are forced low during reset so nothing fires in a reset cycle.
  assign enq_rdy = reset_n && (state_q != ST_TWO);
`ifdef VC_SKID_BUFFER_BYPASS_EN
  assign deq_val = reset_n && ((state_q != ST_EMPTY) || enq_val);
`else
  assign deq_val = reset_n && (state_q != ST_EMPTY);
`endif
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;
  assign count    = state_q;

  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    main_sel = MAIN_SEL_ENQ;
    case (state_q)
      ST_EMPTY: begin
        if (enq_fire) begin
`ifdef VC_SKID_BUFFER_BYPASS_EN
          // A same-cycle dequeue consumes the bypassed message; nothing is stored.
          if (!deq_rdy) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
`else
          state_d = ST_ONE;
          main_en = 1'b1;
`endif
        end
      end
      ST_ONE: begin
        if (enq_fire && deq_fire) begin
          main_en = 1'b1;
        end else if (enq_fire) begin
          state_d = ST_TWO;
          skid_en = 1'b1;
        end else if (deq_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (deq_fire) begin
          state_d  = ST_ONE;
          main_en  = 1'b1;
          main_sel = MAIN_SEL_SKID;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

endmodule

// File: rtl/vc_skid_buffer.sv
// Two-entry val/rdy skid buffer; main register is the head, skid register the second entry.
// Latency: 1 cycle enq->deq when empty, 0 cycles when VC_SKID_BUFFER_BYPASS_EN is defined.
// Backpressure: enq_rdy is registered-state only, so deq_rdy never reaches enq_rdy combinationally.
module vc_skid_buffer
  import vc_skid_buffer_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enq_val,
  output logic         enq_rdy,
  input  logic [W-1:0] enq_msg,
  output logic         deq_val,
  input  logic         deq_rdy,
  output logic [W-1:0] deq_msg,
  output logic [1:0]   count
);

  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         main_en;
  logic         skid_en;
  logic         main_sel;

  vc_skid_buffer_ctrl u_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq_val  (enq_val),
    .deq_rdy  (deq_rdy),
    .enq_rdy  (enq_rdy),
    .deq_val  (deq_val),
    .count    (count),
    .main_en  (main_en),
    .skid_en  (skid_en),
    .main_sel (main_sel)
  );

  // Data registers carry no reset; validity lives entirely in the control state.
  always_ff @(posedge clk) begin
    if (main_en) main_q <= (main_sel == MAIN_SEL_SKID) ? skid_q : enq_msg;
    if (skid_en) skid_q <= enq_msg;
  end

`ifdef VC_SKID_BUFFER_BYPASS_EN
  assign deq_msg = (count == ST_EMPTY) ? enq_msg : main_q;
`else
  assign deq_msg = main_q;
`endif

endmodule
